vfpu_stream_engine: RTL and testbench

- Datapath-side engine directly downstream of the HWPE control/streamer stage. Joins operand streams A and B from the source streamers and issues operand pairs to an external fixed-latency FP unit.
- Collects FP results in an internal credit-protected FIFO and presents them as the result stream to the sink streamer.
- Signals completion to the control stage once the programmed element count has been delivered.

---
 rtl/vfpu_stream_engine.sv | 166 ++++++++++++++++
 tb/tb_vfpu_stream_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_stream_engine.sv
// Joins operand streams A/B, issues pairs to a fixed-latency FPU and buffers results in a credit-protected FWFT FIFO.
// Issue only when FIFO space covers all in-flight results; done_o pulses once the programmed count has been delivered.
module vfpu_stream_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int FPU_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic                  operation_i,
  input  logic [CNT_WIDTH-1:0]  n_elem_i,
  input  logic                  a_valid_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_ready_o,
  output logic                  fpu_valid_o,
  output logic                  fpu_op_o,
  output logic [DATA_WIDTH-1:0] fpu_a_o,
  output logic [DATA_WIDTH-1:0] fpu_b_o,
  input  logic [DATA_WIDTH-1:0] fpu_result_i,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  r_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]      DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  if (FPU_LATENCY < 1) begin : g_lat_chk
    $error("FPU_LATENCY must be at least 1");
  end
  if (FIFO_DEPTH < FPU_LATENCY + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least FPU_LATENCY+1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   op_q, op_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   n_q, n_d;
  logic [CNT_WIDTH-1:0]   issued_cnt_q, issued_cnt_d;
  logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [FPU_LATENCY-1:0] sr_q, sr_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic issue, retire, pop, credit_ok, start_ok;

  // Credit: every in-flight result already owns a FIFO slot, so a retire can never find the FIFO full.
  always_comb begin
    pop       = (fifo_cnt_q != '0) & r_ready_i;
    credit_ok = (({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) - {{CW{1'b0}}, pop}) < DEPTH_L;
    issue     = (state_q == S_RUN) & a_valid_i & b_valid_i & (issued_cnt_q != n_q) & credit_ok;
    retire    = sr_q[FPU_LATENCY-1];
    start_ok  = (state_q == S_IDLE) & start_i;
  end

  assign a_ready_o   = issue;
  assign b_ready_o   = issue;
  assign fpu_valid_o = issue;
  assign fpu_op_o    = op_q;
  assign fpu_a_o     = issue ? a_data_i : '0;
  assign fpu_b_o     = issue ? b_data_i : '0;
  assign r_valid_o   = (fifo_cnt_q != '0);
  assign r_data_o    = r_valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d = operation_i;
          n_d  = n_elem_i;
          if (n_elem_i == '0) done_d  = 1'b1;
          else                state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issued_cnt_q + CNT_WIDTH'(1) == n_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (out_cnt_q + CNT_WIDTH'(1) == n_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issued_cnt_d = start_ok ? '0 : issued_cnt_q + CNT_WIDTH'(issue);
    out_cnt_d    = start_ok ? '0 : out_cnt_q + CNT_WIDTH'(pop);
    sr_d         = sr_q << 1;
    sr_d[0]      = issue;
    inflight_d   = inflight_q;
    unique case ({issue, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    unique case ({retire, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    wr_ptr_d = wr_ptr_q;
    if (retire) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      n_q          <= '0;
      done_q       <= 1'b0;
      issued_cnt_q <= '0;
      out_cnt_q    <= '0;
      sr_q         <= '0;
      inflight_q   <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      assert (!(retire && (fifo_cnt_q == CW'(FIFO_DEPTH))));
      state_q      <= state_d;
      op_q         <= op_d;
      n_q          <= n_d;
      done_q       <= done_d;
      issued_cnt_q <= issued_cnt_d;
      out_cnt_q    <= out_cnt_d;
      sr_q         <= sr_d;
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage is never reset; the read port is gated by r_valid_o so stale words stay hidden.
  always_ff @(posedge clk_i) begin
    if (retire) mem_q[wr_ptr_q] <= fpu_result_i;
  end

endmodule

// File: tb/tb_vfpu_stream_engine.sv
// Self-checking bench for vfpu_stream_engine: FPU pipeline model plus result scoreboard.
module tb_vfpu_stream_engine;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int CNW = 16;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, start_i, operation_i;
  logic [CNW-1:0] n_elem_i;
  logic          a_valid_i, b_valid_i, r_ready_i;
  logic [DW-1:0] a_data_i, b_data_i;
  logic          a_ready_o, b_ready_o, fpu_valid_o, fpu_op_o, r_valid_o, busy_o, done_o;
  logic [DW-1:0] fpu_a_o, fpu_b_o, fpu_result_i, r_data_o;

  int checks = 0, failures = 0;
  int a_hs_cnt = 0, b_hs_cnt = 0, issue_seen = 0, pop_seen = 0, done_seen = 0;
  logic          tb_op = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;
  logic [DW-1:0] pipe [LAT];

  always #5 clk = ~clk;

  vfpu_stream_engine #(.DATA_WIDTH(DW), .FPU_LATENCY(LAT), .FIFO_DEPTH(DEP), .CNT_WIDTH(CNW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .operation_i(operation_i),
    .n_elem_i(n_elem_i), .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o), .fpu_valid_o(fpu_valid_o),
    .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_result_i(fpu_result_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_ready_i(r_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [DW-1:0] model(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return op ? a * b : a + b;
  endfunction

  // External FPU stand-in: result appears exactly LAT cycles after issue, junk otherwise.
  always @(posedge clk) begin
    pipe[0] <= fpu_valid_o ? model(fpu_op_o, fpu_a_o, fpu_b_o) : 32'hBAD0_0000;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_result_i = pipe[LAT-1];

  always @(negedge clk) begin
    if (!rst_i) begin
      if (a_valid_i && a_ready_o) a_hs_cnt++;
      if (b_valid_i && b_ready_o) b_hs_cnt++;
      if (a_valid_i && a_ready_o && b_valid_i && b_ready_o) begin
        issue_seen++;
        exp_q.push_back(model(tb_op, a_data_i, b_data_i));
      end
      if (r_valid_o && r_ready_i) begin
        pop_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected: got %h, expected no result", r_data_o);
        end else begin
          sb_exp = exp_q.pop_front();
          if (r_data_o !== sb_exp) begin
            failures++;
            $display("FAIL result_data: got %h, expected %h", r_data_o, sb_exp);
          end
        end
      end
      if (done_o === 1'b1) done_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    a_data_i = 32'h10 + 32'(a_hs_cnt) * 32'd3;
    b_data_i = 32'h200 + 32'(b_hs_cnt) * 32'd5;
  endtask

  task automatic start_job(input logic op, input int n);
    step();
    operation_i = op;
    n_elem_i    = CNW'(n);
    start_i     = 1'b1;
    tb_op       = op;
    step();
    start_i     = 1'b0;
  endtask

  task automatic run_to_idle(input int max);
    int used = 0;
    @(negedge clk);
    while (busy_o && used < max) begin
      step();
      @(negedge clk);
      used++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL job_timeout: busy=%b after %0d cycles, expected 0", busy_o, used);
    end
    step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, r_valid_o, fpu_valid_o, a_ready_o, b_ready_o, fpu_op_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {busy_o, done_o, r_valid_o, fpu_valid_o, a_ready_o, b_ready_o, fpu_op_o});
    end
    checks++;
    if ({r_data_o, fpu_a_o, fpu_b_o} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data: r=%h a=%h b=%h, expected all 0", r_data_o, fpu_a_o, fpu_b_o);
    end
  endtask

  task automatic test_basic_add();
    int d0 = done_seen;
    a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
    start_job(1'b0, 4);
    for (int k = 1; k <= 10; k++) begin
      logic [3:0] exp_v;
      if (k > 1) step();
      @(negedge clk);
      exp_v = {(k >= 1 && k <= 4), (k >= 5 && k <= 8), (k == 9), (k <= 8)};
      checks++;
      if ({fpu_valid_o, r_valid_o, done_o, busy_o} !== exp_v) begin
        failures++;
        $display("FAIL basic_timing k=%0d: fv/rv/done/busy=%b, expected %b", k,
                 {fpu_valid_o, r_valid_o, done_o, busy_o}, exp_v);
      end
    end
    checks++;
    if (done_seen - d0 !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL basic_end: done=%0d pending=%0d, expected 1 and 0", done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int d0 = done_seen, i0 = issue_seen, p0 = pop_seen;
    a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b0;
    start_job(1'b0, 8);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      @(negedge clk);
    end
    checks++;
    if (issue_seen - i0 !== DEP) begin
      failures++;
      $display("FAIL bp_issues: got %0d, expected %0d", issue_seen - i0, DEP);
    end
    checks++;
    if ({a_ready_o, b_ready_o, r_valid_o} !== 3'b001) begin
      failures++;
      $display("FAIL bp_stall: a_rdy/b_rdy/r_vld=%b, expected 001", {a_ready_o, b_ready_o, r_valid_o});
    end
    step();
    r_ready_i = 1'b1;
    run_to_idle(60);
    checks++;
    if (issue_seen - i0 !== 8 || pop_seen - p0 !== 8 || done_seen - d0 !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_end: issues=%0d pops=%0d done=%0d pending=%0d, expected 8 8 1 0",
               issue_seen - i0, pop_seen - p0, done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_join_skew();
    int d0 = done_seen, i0 = issue_seen;
    a_valid_i = 1'b1; b_valid_i = 1'b0; r_ready_i = 1'b1;
    start_job(1'b0, 2);
    for (int k = 1; k <= 2; k++) begin
      if (k > 1) step();
      @(negedge clk);
      checks++;
      if ({a_ready_o, b_ready_o, fpu_valid_o} !== 3'b000) begin
        failures++;
        $display("FAIL skew_wait k=%0d: a_rdy/b_rdy/fv=%b, expected 000", k, {a_ready_o, b_ready_o, fpu_valid_o});
      end
    end
    step();
    b_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready_o, b_ready_o, fpu_valid_o} !== 3'b111) begin
      failures++;
      $display("FAIL skew_first: a_rdy/b_rdy/fv=%b, expected 111", {a_ready_o, b_ready_o, fpu_valid_o});
    end
    run_to_idle(30);
    checks++;
    if (issue_seen - i0 !== 2 || done_seen - d0 !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL skew_end: issues=%0d done=%0d pending=%0d, expected 2 1 0",
               issue_seen - i0, done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_seen, i0 = issue_seen;
    a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
    start_job(1'b1, 0);
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b10) begin
      failures++;
      $display("FAIL zero_done: done/busy=%b, expected 10", {done_o, busy_o});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      checks++;
      if ({done_o, busy_o, fpu_valid_o} !== 3'b000) begin
        failures++;
        $display("FAIL zero_quiet k=%0d: done/busy/fv=%b, expected 000", k, {done_o, busy_o, fpu_valid_o});
      end
    end
    checks++;
    if (issue_seen - i0 !== 0 || done_seen - d0 !== 1) begin
      failures++;
      $display("FAIL zero_end: issues=%0d done=%0d, expected 0 1", issue_seen - i0, done_seen - d0);
    end
  endtask

  task automatic test_clear();
    int d0, i0;
    a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
    start_job(1'b0, 4);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    a_valid_i = 1'b0; b_valid_i = 1'b0; clear_i = 1'b1;
    @(negedge clk);
    step();
    clear_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, r_valid_o, fpu_valid_o, a_ready_o, b_ready_o, fpu_op_o} !== 7'b0 || r_data_o !== 32'h0) begin
      failures++;
      $display("FAIL clear_outputs: ctrl=%b r_data=%h, expected 0000000 and 0",
               {busy_o, done_o, r_valid_o, fpu_valid_o, a_ready_o, b_ready_o, fpu_op_o}, r_data_o);
    end
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (r_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL clear_stale k=%0d: r_valid=%b data=%h, expected 0", k, r_valid_o, r_data_o);
      end
    end
    d0 = done_seen; i0 = issue_seen;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    start_job(1'b1, 3);
    run_to_idle(30);
    checks++;
    if (issue_seen - i0 !== 3 || done_seen - d0 !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL clear_rerun: issues=%0d done=%0d pending=%0d, expected 3 1 0",
               issue_seen - i0, done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_op_latch();
    int d0 = done_seen, i0 = issue_seen, bad = 0, used = 0;
    a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
    start_job(1'b1, 5);
    @(negedge clk);
    step();
    operation_i = 1'b0; n_elem_i = 16'd2; start_i = 1'b1;
    @(negedge clk);
    step();
    start_i = 1'b0;
    @(negedge clk);
    while (busy_o && used < 40) begin
      if (fpu_valid_o && fpu_op_o !== 1'b1) bad++;
      step();
      @(negedge clk);
      used++;
    end
    step();
    @(negedge clk);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL op_latch: %0d issues with fpu_op!=1, expected 0", bad);
    end
    checks++;
    if (issue_seen - i0 !== 5 || done_seen - d0 !== 1 || exp_q.size() !== 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL op_restart: issues=%0d done=%0d pending=%0d busy=%b, expected 5 1 0 0",
               issue_seen - i0, done_seen - d0, exp_q.size(), busy_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; operation_i = 1'b0; n_elem_i = '0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; r_ready_i = 1'b0;
    a_data_i = 32'h10; b_data_i = 32'h200;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic_add();
    test_backpressure();
    test_join_skew();
    test_zero_len();
    test_clear();
    test_op_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
